// File: rtl/data_router_pkg.sv
// Shared types for the data-router read path.
//   sched_state_e : read scheduler FSM states
//   BANKW         : width of every bank select in the router (fixed at 2 bits)
//   bank_sel_t    : bank select type
package data_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    READ,
    DRAIN,
    FIN
  } sched_state_e;

  localparam int unsigned BANKW = 2;

  typedef logic [BANKW-1:0] bank_sel_t;

endpackage

// File: rtl/bank_rd_sched_out_stage.sv
// rd_out_stage: one-deep valid/ready register that sits behind the bank
// buffers' 1-cycle read. It carries the bank select and last flags for the
// word the buffer returns, and pulses bank_release when a visit's final
// word is accepted downstream.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   issue             a buffer read is issued this cycle
//   issue_bank        bank of the issued read
//   issue_last_bank   issued word is the last of its bank visit
//   issue_last        issued word is the last of the job
//   out_ready         downstream accepts the current word
//   out_valid         returned word valid
//   bank              mux select aligned with the returned word
//   out_last_bank     returned word is the last of its bank visit
//   out_last          returned word is the last of the job
//   bank_release      one-hot pulse: bank fully consumed
module rd_out_stage
  import data_router_pkg::*;
#(
  parameter int unsigned POY = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           issue,
  input  bank_sel_t      issue_bank,
  input  logic           issue_last_bank,
  input  logic           issue_last,
  input  logic           out_ready,
  output logic           out_valid,
  output bank_sel_t      bank,
  output logic           out_last_bank,
  output logic           out_last,
  output logic [POY-1:0] bank_release
);

  logic fire_last_bank;

  // The scheduler only issues when this register is empty or draining,
  // so a new issue never overwrites a word that has not been accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      bank          <= '0;
      out_last_bank <= 1'b0;
      out_last      <= 1'b0;
    end else if (issue) begin
      out_valid     <= 1'b1;
      bank          <= issue_bank;
      out_last_bank <= issue_last_bank;
      out_last      <= issue_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign fire_last_bank = out_valid && out_ready && out_last_bank;

  // Release follows acceptance of the final word, not its issue, so the
  // writer cannot refill a bank whose last word is still in flight.
  always_comb begin
    bank_release = '0;
    for (int unsigned i = 0; i < POY; i++) begin
      bank_release[i] = fire_last_bank && (bank == bank_sel_t'(i));
    end
  end

endmodule

// File: rtl/bank_rd_sched.sv
// bank_rd_sched: read scheduler for the POY-bank output-row buffers feeding
// the data-router bank mux. Rotates the read bank 0..POY-1, reads cfg_len
// words per bank visit, repeats cfg_passes rotations, and presents each
// returned word with a bank select aligned to the buffer's 1-cycle latency.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle pulse, begins a job when idle
//   cfg_len        words per bank visit (sampled at start)
//   cfg_passes     full rotations per job (sampled at start)
//   bank_ready     per-bank level: bank filled and readable
//   bank_release   per-bank pulse: bank fully consumed
//   rd_en/rd_bank/rd_addr  buffer read strobe, bank and word address
//   bank           mux select aligned with returned data
//   out_valid/out_ready    output word handshake
//   out_last_bank  last word of the bank visit
//   out_last       last word of the job
//   busy           job in progress
//   done           one-cycle pulse at job end
module bank_rd_sched
  import data_router_pkg::*;
#(
  parameter int unsigned POY = 3,
  parameter int unsigned AW  = 8,
  parameter int unsigned PW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    cfg_len,
  input  logic [PW-1:0]    cfg_passes,
  input  logic [POY-1:0]   bank_ready,
  output logic [POY-1:0]   bank_release,
  output logic             rd_en,
  output logic [BANKW-1:0] rd_bank,
  output logic [AW-1:0]    rd_addr,
  output logic [BANKW-1:0] bank,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last_bank,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  sched_state_e  state;
  logic [AW-1:0] len_q;
  logic [AW-1:0] addr;
  logic [PW-1:0] passes_q;
  logic [PW-1:0] pass;
  bank_sel_t     bank_cnt;
  logic          busy_q;
  logic          done_q;

  logic ready_cur;
  logic out_free;
  logic issue;
  logic visit_end;
  logic bank_wrap;
  logic last_pass;
  logic issue_last;

  // bank_cnt never exceeds POY-1; the loop keeps the select in range for POY < 4.
  always_comb begin
    ready_cur = 1'b0;
    for (int unsigned i = 0; i < POY; i++) begin
      if (bank_cnt == bank_sel_t'(i)) ready_cur = bank_ready[i];
    end
  end

  assign out_free   = !out_valid || out_ready;
  assign issue      = (state == READ) && ready_cur && out_free;
  assign visit_end  = (addr == len_q - AW'(1));
  assign bank_wrap  = (bank_cnt == bank_sel_t'(POY - 1));
  assign last_pass  = (pass == passes_q - PW'(1));
  assign issue_last = visit_end && bank_wrap && last_pass;

  // The read strobe is combinational so the word lands in the output
  // register exactly one cycle later, alongside its registered bank select.
  assign rd_en   = issue;
  assign rd_bank = issue ? bank_cnt : '0;
  assign rd_addr = issue ? addr : '0;

  assign busy = busy_q;
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_q    <= '0;
      passes_q <= '0;
      addr     <= '0;
      pass     <= '0;
      bank_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            if ((cfg_len != '0) && (cfg_passes != '0)) begin
              len_q    <= cfg_len;
              passes_q <= cfg_passes;
              addr     <= '0;
              pass     <= '0;
              bank_cnt <= '0;
              busy_q   <= 1'b1;
              state    <= WAIT;
            end else begin
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        WAIT: begin
          if (ready_cur) state <= READ;
        end
        READ: begin
          if (issue) begin
            if (visit_end) begin
              addr <= '0;
              if (bank_wrap) begin
                bank_cnt <= '0;
                if (!last_pass) pass <= pass + PW'(1);
              end else begin
                bank_cnt <= bank_cnt + bank_sel_t'(1);
              end
              state <= issue_last ? DRAIN : WAIT;
            end else begin
              addr <= addr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_out_stage #(
    .POY(POY)
  ) u_out_stage (
    .clk            (clk),
    .rst            (rst),
    .issue          (issue),
    .issue_bank     (bank_cnt),
    .issue_last_bank(visit_end),
    .issue_last     (issue_last),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .bank           (bank),
    .out_last_bank  (out_last_bank),
    .out_last       (out_last),
    .bank_release   (bank_release)
  );

endmodule

// File: tb/tb_bank_rd_sched.sv
// Testbench for bank_rd_sched: a job-level model (expected beat list built
// from len/passes loops) checked every cycle, plus directed literal checks.
module tb_bank_rd_sched;

  localparam int unsigned POY = 3;
  localparam int unsigned AW  = 8;
  localparam int unsigned PW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [AW-1:0]  cfg_len = '0;
  logic [PW-1:0]  cfg_passes = '0;
  logic [POY-1:0] bank_ready = '0;
  logic [POY-1:0] bank_release;
  logic           rd_en;
  logic [1:0]     rd_bank;
  logic [AW-1:0]  rd_addr;
  logic [1:0]     bank;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           out_last_bank;
  logic           out_last;
  logic           busy;
  logic           done;

  always #5 clk = ~clk;

  bank_rd_sched #(
    .POY(POY),
    .AW (AW),
    .PW (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_len      (cfg_len),
    .cfg_passes   (cfg_passes),
    .bank_ready   (bank_ready),
    .bank_release (bank_release),
    .rd_en        (rd_en),
    .rd_bank      (rd_bank),
    .rd_addr      (rd_addr),
    .bank         (bank),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last_bank(out_last_bank),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done)
  );

  // Buffer model: 1-cycle read, output held while rd_en is low.
  logic [15:0] buf_q = '0;
  always @(posedge clk) if (rd_en) buf_q <= {6'd0, rd_bank, rd_addr};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // mstate: 0 idle, 1 job running, 2 done cycle
  int mstate = 0;
  int eb[512];
  int ea[512];
  int elb[512];
  int el[512];
  int nb = 0, iss_i = 0, acc_i = 0;
  int total_acc = 0, rel_cnt = 0, done_cnt = 0;
  int done_cyc = 0, first_b1_cyc = -1;
  bit post_rst = 0, prev_stall = 0;
  int prev_word = 0;

  always @(negedge clk) begin
    int nxt, exp_rel, b;
    bit acc;
    if (rst) begin
      mstate = 0; nb = 0; iss_i = 0; acc_i = 0;
      post_rst = 1; prev_stall = 0;
    end else begin
      nxt = mstate;
      if (post_rst) begin
        chk("reset_outputs", int'({out_valid, rd_en, bank, out_last_bank, out_last,
                                   busy, done, bank_release}), 0);
        post_rst = 0;
      end
      chk("busy", int'(busy), int'(mstate == 1));
      chk("done", int'(done), int'(mstate == 2));
      if (done) begin done_cnt++; done_cyc = cyc; end

      if (prev_stall)
        chk("stall_hold", int'({out_valid, bank, out_last_bank, out_last, buf_q}), prev_word);

      // read side
      if (mstate == 1 && iss_i < nb) begin
        b = eb[iss_i];
        if (!(bank_ready[b] && (!out_valid || out_ready)))
          chk("no_issue_when_blocked", int'(rd_en), 0);
        else if (iss_i > 0 && elb[iss_i-1] == 0)
          chk("issue_streams", int'(rd_en), 1);
        if (rd_en) begin
          chk("rd_bank", int'(rd_bank), eb[iss_i]);
          chk("rd_addr", int'(rd_addr), ea[iss_i]);
          if (rd_bank == 2'd1 && first_b1_cyc < 0) first_b1_cyc = cyc;
          iss_i++;
        end
      end else begin
        chk("no_rd_en", int'(rd_en), 0);
      end

      // output side
      acc = out_valid && out_ready;
      exp_rel = 0;
      if (out_valid && !(mstate == 1 && acc_i < iss_i))
        chk("unexpected_valid", int'(out_valid), 0);
      if (acc && mstate == 1 && acc_i < iss_i) begin
        chk("out_bank", int'(bank), eb[acc_i]);
        chk("data_addr", int'(buf_q[7:0]), ea[acc_i]);
        chk("data_bank_align", int'(buf_q[9:8]), int'(bank));
        chk("out_last_bank", int'(out_last_bank), elb[acc_i]);
        chk("out_last", int'(out_last), el[acc_i]);
        if (elb[acc_i] != 0) exp_rel = 1 << eb[acc_i];
        if (el[acc_i] != 0) nxt = 2;
        acc_i++;
        total_acc++;
      end
      chk("bank_release", int'(bank_release), exp_rel);
      if (bank_release != '0) rel_cnt++;

      prev_stall = out_valid && !out_ready;
      prev_word  = int'({out_valid, bank, out_last_bank, out_last, buf_q});

      case (mstate)
        0: if (start) begin
          if (cfg_len == '0 || cfg_passes == '0) nxt = 2;
          else begin
            nb = 0; iss_i = 0; acc_i = 0;
            for (int p = 0; p < int'(cfg_passes); p++)
              for (int bk = 0; bk < int'(POY); bk++)
                for (int a = 0; a < int'(cfg_len); a++) begin
                  eb[nb]  = bk;
                  ea[nb]  = a;
                  elb[nb] = int'(a == int'(cfg_len) - 1);
                  el[nb]  = int'(a == int'(cfg_len) - 1 && bk == int'(POY) - 1 &&
                                 p == int'(cfg_passes) - 1);
                  nb++;
                end
            nxt = 1;
          end
        end
        2: nxt = 0;
        default: ;
      endcase
      mstate = nxt;
    end
  end

  // ---------------- stimulus ----------------
  // or_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random; rdy_rand randomizes bank_ready
  int or_mode = 0;
  bit rdy_rand = 0;
  int pat_i = 0;
  always @(posedge clk) begin
    #1;
    case (or_mode)
      1: begin out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
      2: out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b1;
    endcase
    if (rdy_rand)
      for (int i = 0; i < int'(POY); i++) bank_ready[i] = ($urandom_range(0, 3) != 0);
  end

  int start_cyc = 0;

  task automatic pulse_start(input int len, input int passes);
    @(posedge clk); #1;
    cfg_len    = AW'(len);
    cfg_passes = PW'(passes);
    start      = 1'b1;
    start_cyc  = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (mstate != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mstate != 0) chk("wait_idle_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int a0, r0, d0, rdy_cyc, n, len, passes;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bank_ready = '1;
    repeat (2) @(posedge clk);
    #1;

    // T1: len 4, 1 pass, everything ready
    a0 = total_acc; r0 = rel_cnt; d0 = done_cnt;
    pulse_start(4, 1);
    wait_idle(200);
    chk("t1_beats", total_acc - a0, 12);
    chk("t1_releases", rel_cnt - r0, 3);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_latency", done_cyc - start_cyc, 17);

    // T2: bank 1 not ready for 20 cycles
    a0 = total_acc; first_b1_cyc = -1;
    bank_ready = 3'b101;
    pulse_start(4, 1);
    repeat (20) @(posedge clk);
    #1 bank_ready = '1;
    rdy_cyc = cyc;
    wait_idle(200);
    chk("t2_beats", total_acc - a0, 12);
    chk("t2_bank1_gap", first_b1_cyc - rdy_cyc, 1);

    // T3: out_ready pattern 1,0,0,1
    a0 = total_acc; r0 = rel_cnt;
    or_mode = 1; pat_i = 0;
    pulse_start(4, 1);
    wait_idle(400);
    or_mode = 0;
    chk("t3_beats", total_acc - a0, 12);
    chk("t3_releases", rel_cnt - r0, 3);

    // T4: len 2, 3 passes
    a0 = total_acc; r0 = rel_cnt; d0 = done_cnt;
    pulse_start(2, 3);
    wait_idle(400);
    chk("t4_beats", total_acc - a0, 18);
    chk("t4_releases", rel_cnt - r0, 9);
    chk("t4_done", done_cnt - d0, 1);

    // T5: zero length / zero passes
    a0 = total_acc; d0 = done_cnt;
    pulse_start(0, 2);
    wait_idle(20);
    chk("t5_len0_latency", done_cyc - start_cyc, 1);
    pulse_start(3, 0);
    wait_idle(20);
    chk("t5_beats", total_acc - a0, 0);
    chk("t5_done", done_cnt - d0, 2);

    // T6: start while busy is ignored
    a0 = total_acc;
    pulse_start(3, 1);
    repeat (3) @(posedge clk);
    #1;
    pulse_start(5, 2);
    wait_idle(400);
    chk("t6_beats", total_acc - a0, 9);

    // T7: reset mid-job at beat 5, then a clean job
    a0 = total_acc;
    pulse_start(4, 1);
    n = 0;
    while (total_acc - a0 < 5 && n < 200) begin @(negedge clk); n++; end
    chk("t7_reach_beat5", total_acc - a0, 5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    d0 = done_cnt; r0 = rel_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("t7_no_done_after_rst", done_cnt - d0, 0);
    chk("t7_no_release_after_rst", rel_cnt - r0, 0);
    a0 = total_acc;
    pulse_start(4, 1);
    wait_idle(200);
    chk("t7_fresh_beats", total_acc - a0, 12);

    // T8: randomized jobs with random out_ready and bank_ready
    or_mode = 2; rdy_rand = 1;
    for (int j = 0; j < 8; j++) begin
      len    = $urandom_range(1, 5);
      passes = $urandom_range(1, 3);
      a0 = total_acc;
      pulse_start(len, passes);
      wait_idle(len * passes * int'(POY) * 12 + 200);
      chk("t8_beats", total_acc - a0, len * int'(POY) * passes);
    end
    or_mode = 0; rdy_rand = 0;
    bank_ready = '1;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
